bus_slave_mem: RTL and testbench

BUS_SLAVE_MEM -- requirements
Module: bus_slave_mem

---
 rtl/bus_slave_mem_pkg.sv | 32 +++
 rtl/bus_slave_mem_if.sv | 23 ++
 rtl/bus_slave_mem_ram.sv | 28 ++
 rtl/bus_slave_mem.sv | 89 ++++++++
 tb/tb_bus_slave_mem.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_slave_mem_pkg.sv
// Shared CPU bus definitions: word/address widths, slave-index field,
// transfer direction and the slave handshake state encoding.
package bus_slave_mem_pkg;

  localparam int WORD_W      = 32;
  localparam int WORD_ADDR_W = 30;

  // Slave-select field inside a word address
  localparam int SLV_IDX_HI  = 29;
  localparam int SLV_IDX_LO  = 27;
  localparam int SLV_IDX_W   = SLV_IDX_HI - SLV_IDX_LO + 1;

  typedef logic [WORD_W-1:0]      word_t;
  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [SLV_IDX_W-1:0]   slv_idx_t;

  typedef enum logic {
    BUS_READ  = 1'b0,
    BUS_WRITE = 1'b1
  } bus_rw_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } slave_state_e;

  function automatic slv_idx_t slave_index(input word_addr_t addr);
    return addr[SLV_IDX_HI:SLV_IDX_LO];
  endfunction

endpackage

// File: rtl/bus_slave_mem_if.sv
// Bus connection between one initiator and a memory-mapped slave.
interface bus_slave_mem_if;
  import bus_slave_mem_pkg::*;

  word_addr_t bus_addr;
  logic       bus_as;
  logic       bus_rw;
  word_t      bus_wr_data;
  word_t      bus_rd_data;
  logic       bus_rdy;
  logic       busy;

  modport master (
    output bus_addr, bus_as, bus_rw, bus_wr_data,
    input  bus_rd_data, bus_rdy, busy
  );

  modport slave (
    input  bus_addr, bus_as, bus_rw, bus_wr_data,
    output bus_rd_data, bus_rdy, busy
  );

endinterface

// File: rtl/bus_slave_mem_ram.sv
// Single-port word RAM: synchronous write, registered read, no reset so it
// can map onto block RAM.
module bus_slave_ram
  import bus_slave_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_slave_mem.sv
// Memory slave on the CPU bus: accepts one selected strobe at a time, inserts
// WAIT_CYCLES wait states, then completes with a one-cycle bus_rdy pulse.
module bus_slave_mem
  import bus_slave_mem_pkg::*;
#(
  parameter slv_idx_t SLAVE_ID    = 3'd2,
  parameter int       DEPTH_LOG2  = 8,
  parameter int       WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  bus_slave_mem_if.slave  bus
);

  slave_state_e          state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  sel;
  logic                  load;
  logic                  ram_en;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  rw_q;
  word_t                 wdata_q;
  word_t                 ram_rdata;

  assign sel = bus.bus_as && (slave_index(bus.bus_addr) == SLAVE_ID);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    ram_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sel) begin
          state_nx = ST_WAIT;
          cnt_nx   = 4'(WAIT_CYCLES);
          load     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          // The RAM access happens on the edge that enters READY
          state_nx = ST_READY;
          ram_en   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_READY: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) begin
        idx_q   <= bus.bus_addr[DEPTH_LOG2-1:0];
        rw_q    <= bus.bus_rw;
        wdata_q <= bus.bus_wr_data;
      end
    end
  end

  bus_slave_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (rw_q == BUS_WRITE),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The RAM output register is not reset; gating by READY keeps the bus
  // output at zero outside the completion cycle so slaves can be OR-ed.
  assign bus.bus_rdy     = (state == ST_READY);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.bus_rd_data = (state == ST_READY && rw_q == BUS_READ) ? ram_rdata : '0;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Drives two bus_slave_mem instances (WAIT_CYCLES 2 and 0) from one stimulus
// stream and scores each against a transaction-level model.
module tb_bus_slave_mem;
  import bus_slave_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [29:0] addr = '0;
  logic        as_  = 1'b0;
  logic        rw   = 1'b0;
  logic [31:0] wd   = '0;

  bus_slave_mem_if bus_w2 ();
  bus_slave_mem_if bus_w0 ();

  assign bus_w2.bus_addr    = addr;
  assign bus_w2.bus_as      = as_;
  assign bus_w2.bus_rw      = rw;
  assign bus_w2.bus_wr_data = wd;
  assign bus_w0.bus_addr    = addr;
  assign bus_w0.bus_as      = as_;
  assign bus_w0.bus_rw      = rw;
  assign bus_w0.bus_wr_data = wd;

  bus_slave_mem #(.SLAVE_ID(3'd2), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .bus(bus_w2)
  );
  bus_slave_mem #(.SLAVE_ID(3'd2), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .bus(bus_w0)
  );

  logic        rdy_s  [2];
  logic        busy_s [2];
  logic [31:0] data_s [2];
  assign rdy_s[0]  = bus_w2.bus_rdy;
  assign rdy_s[1]  = bus_w0.bus_rdy;
  assign busy_s[0] = bus_w2.busy;
  assign busy_s[1] = bus_w0.busy;
  assign data_s[0] = bus_w2.bus_rd_data;
  assign data_s[1] = bus_w0.bus_rd_data;

  // Reference model: a slave is free again WAIT+3 edges after accepting,
  // completes WAIT+1 edges after accepting, memory is addr mod 256.
  typedef struct {
    int          k;
    int          due;
    logic        rw;
    logic [7:0]  idx;
    logic [31:0] wd;
  } txn_t;

  txn_t        q[$];
  int          wc     [2] = '{2, 0};
  int          free_e [2] = '{0, 0};
  int          acc_e  [2] = '{-100, -100};
  logic [31:0] mm     [2][256];
  bit          kn     [2][256];
  int          cyc    = 0;
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst && as_ && addr[29:27] == 3'd2) begin
      for (int k = 0; k < 2; k++) begin
        if (cyc >= free_e[k]) begin
          free_e[k] = cyc + wc[k] + 3;
          acc_e[k]  = cyc;
          q.push_back('{k: k, due: cyc + wc[k] + 1, rw: rw, idx: addr[7:0], wd: wd});
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    int   hit;
    logic bexp;
    txn_t t;
    if (!rst) begin
      q.delete();
      for (int k = 0; k < 2; k++) begin
        free_e[k] = 0;
        acc_e[k]  = -100;
        chk("reset_rdy",  k, {31'b0, rdy_s[k]},  32'd0);
        chk("reset_busy", k, {31'b0, busy_s[k]}, 32'd0);
        chk("reset_data", k, data_s[k], 32'd0);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        hit = -1;
        foreach (q[i]) if (q[i].k == k && q[i].due == cyc) hit = i;
        bexp = (cyc >= acc_e[k]) && (cyc <= acc_e[k] + wc[k] + 1);
        chk("busy", k, {31'b0, busy_s[k]}, {31'b0, bexp});
        if (hit >= 0) begin
          t = q[hit];
          q.delete(hit);
          chk("rdy_pulse", k, {31'b0, rdy_s[k]}, 32'd1);
          if (t.rw) begin
            chk("write_data_zero", k, data_s[k], 32'd0);
            mm[k][t.idx] = t.wd;
            kn[k][t.idx] = 1'b1;
          end else if (kn[k][t.idx]) begin
            chk("read_data", k, data_s[k], mm[k][t.idx]);
          end
        end else begin
          chk("rdy_idle", k, {31'b0, rdy_s[k]}, 32'd0);
          chk("data_idle", k, data_s[k], 32'd0);
        end
      end
    end
  end

  task automatic strobe(input logic [29:0] a, input logic r, input logic [31:0] d,
                        input int hold);
    @(posedge clk);
    #1;
    addr = a;
    rw   = r;
    wd   = d;
    as_  = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    as_  = 1'b0;
    addr = 30'($urandom);
    wd   = $urandom;
    rw   = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic [29:0] ra;
    idle(3);
    #1 rst = 1'b1;
    idle(2);

    // write then read
    strobe({3'd2, 27'h5}, 1'b1, 32'hDEADBEEF, 1);
    idle(6);
    strobe({3'd2, 27'h5}, 1'b0, 32'h0, 1);
    idle(6);

    // another slave's index
    strobe({3'd1, 27'h5}, 1'b0, 32'h0, 1);
    idle(10);

    // aliasing through the ignored middle address bits
    strobe({3'd2, 27'h0ABC105}, 1'b1, 32'h12345678, 1);
    idle(6);
    strobe({3'd2, 27'h0000005}, 1'b0, 32'h0, 1);
    idle(6);

    // strobe held high: back-to-back acceptance, strobes while busy ignored
    strobe({3'd2, 27'h9}, 1'b1, 32'hCAFEF00D, 1);
    idle(6);
    strobe({3'd2, 27'h9}, 1'b0, 32'h0, 9);
    idle(6);

    // reset in WAIT aborts the write
    strobe({3'd2, 27'h7}, 1'b1, 32'h11111111, 1);
    idle(6);
    strobe({3'd2, 27'h7}, 1'b1, 32'hAAAA5555, 1);
    rst = 1'b0;
    #1;
    chk("abort_rdy",  0, {31'b0, bus_w2.bus_rdy}, 32'd0);
    chk("abort_busy", 0, {31'b0, bus_w2.busy},    32'd0);
    chk("abort_rdy",  1, {31'b0, bus_w0.bus_rdy}, 32'd0);
    chk("abort_busy", 1, {31'b0, bus_w0.busy},    32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    strobe({3'd2, 27'h7}, 1'b0, 32'h0, 1);
    idle(6);

    // second selected strobe during the first transfer
    strobe({3'd2, 27'h3}, 1'b1, 32'h0000_00A1, 1);
    strobe({3'd2, 27'h3}, 1'b1, 32'h0000_00B2, 1);
    idle(8);
    strobe({3'd2, 27'h3}, 1'b0, 32'h0, 1);
    idle(6);

    // randomized traffic over a small word window
    for (int n = 0; n < 300; n++) begin
      ra        = 30'($urandom);
      ra[29:27] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd2;
      ra[7:0]   = 8'($urandom_range(0, 31));
      strobe(ra, 1'($urandom), $urandom, $urandom_range(1, 3));
      idle($urandom_range(0, 4));
    end

    idle(10);
    chk("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
